// File: rtl/restador_serial_nbits_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master side drives the request and the operands; the slave side returns status and results.
interface restador_serial_nbits_if #(
    parameter int N = 32
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [N-1:0] q;
    logic         bout;
    logic         v;

    modport master (
        output start, a, b, bin,
        input  busy, done, q, bout, v
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, q, bout, v
    );
endinterface

// File: rtl/restador_serial_nbits.sv
// Bit-serial N-bit subtractor Q = A - B - Bin, processed LSB first with one full-subtractor cell.
// Results are held in registers and update only on the completion edge.
module restador_serial_nbits #(
    parameter int N = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    restador_serial_nbits_if.slave  bus
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   sa_reg, sa_next;
    logic [N-1:0]   sb_reg, sb_next;
    logic [N-1:0]   res_reg, res_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic           br_reg, br_next;
    logic           a_msb_reg, a_msb_next;
    logic           b_msb_reg, b_msb_next;
    logic [N-1:0]   q_reg, q_next;
    logic           bout_reg, bout_next;
    logic           v_reg, v_next;
    logic           done_reg, done_next;

    logic           bit_a, bit_b, bit_d, br_calc;
    logic [N-1:0]   res_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            sa_reg    <= '0;
            sb_reg    <= '0;
            res_reg   <= '0;
            cnt_reg   <= '0;
            br_reg    <= 1'b0;
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            q_reg     <= '0;
            bout_reg  <= 1'b0;
            v_reg     <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sa_reg    <= sa_next;
            sb_reg    <= sb_next;
            res_reg   <= res_next;
            cnt_reg   <= cnt_next;
            br_reg    <= br_next;
            a_msb_reg <= a_msb_next;
            b_msb_reg <= b_msb_next;
            q_reg     <= q_next;
            bout_reg  <= bout_next;
            v_reg     <= v_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sa_next    = sa_reg;
        sb_next    = sb_reg;
        res_next   = res_reg;
        cnt_next   = cnt_reg;
        br_next    = br_reg;
        a_msb_next = a_msb_reg;
        b_msb_next = b_msb_reg;
        q_next     = q_reg;
        bout_next  = bout_reg;
        v_next     = v_reg;
        done_next  = 1'b0;

        // Full-subtractor cell on the current LSBs and the stored borrow
        bit_a     = sa_reg[0];
        bit_b     = sb_reg[0];
        bit_d     = bit_a ^ bit_b ^ br_reg;
        br_calc   = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_reg);
        res_shift = {bit_d, res_reg[N-1:1]};

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    sa_next    = bus.a;
                    sb_next    = bus.b;
                    res_next   = '0;
                    br_next    = bus.bin;
                    cnt_next   = '0;
                    a_msb_next = bus.a[N-1];
                    b_msb_next = bus.b[N-1];
                    state_next = RUN;
                end
            end
            RUN: begin
                sa_next  = sa_reg >> 1;
                sb_next  = sb_reg >> 1;
                res_next = res_shift;
                br_next  = br_calc;
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == CW'(N - 1)) begin
                    // Last bit: bit_d is the result sign, judged against the latched operand signs
                    q_next     = res_shift;
                    bout_next  = br_calc;
                    v_next     = (a_msb_reg != b_msb_reg) && (bit_d != a_msb_reg);
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy = (state_reg == RUN);
    assign bus.done = done_reg;
    assign bus.q    = q_reg;
    assign bus.bout = bout_reg;
    assign bus.v    = v_reg;
endmodule

// File: tb/tb_restador_serial_nbits.sv
// Randomized self-checking bench for the bit-serial subtractor at N=8 and N=32,
// checked against an arithmetic reference model.
module tb_restador_serial_nbits;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    longint last_q8 = 0;

    restador_serial_nbits_if #(.N(8))  bus8 ();
    restador_serial_nbits_if #(.N(32)) bus32 ();

    restador_serial_nbits #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    restador_serial_nbits #(.N(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Difference modulo 2^n, unsigned borrow, and signed range overflow of A - B - Bin
    function automatic void model(input int n, input longint a, input longint b, input bit bin,
                                  output longint q, output bit bout, output bit v);
        longint full, half, sa, sb, sd;
        full = longint'(1) << n;
        half = longint'(1) << (n - 1);
        q    = (a - b - longint'(bin)) & (full - 1);
        bout = (a < b + longint'(bin));
        sa   = (a >= half) ? a - full : a;
        sb   = (b >= half) ? b - full : b;
        sd   = sa - sb - longint'(bin);
        v    = (sd < -half) || (sd > half - 1);
    endfunction

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input bit bin, input int ign);
        longint eq;
        bit     eb, ev, got;
        int     busy_n;
        model(8, longint'(a), longint'(b), bin, eq, eb, ev);
        bus8.a = a; bus8.b = b; bus8.bin = bin; bus8.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        busy_n = 0;
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus8.done) begin
                got = 1'b1;
                break;
            end
            if (bus8.busy) busy_n++;
            chk({tag, "_hold"}, 64'(bus8.q), 64'(last_q8));
            if (i == ign) begin
                bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.bin = 1'b1;
            end else begin
                bus8.start = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, "_done"}, 64'(got), 64'(1));
        chk({tag, "_busy"}, 64'(busy_n), 64'(8));
        chk({tag, "_q"},    64'(bus8.q), 64'(eq));
        chk({tag, "_bout"}, 64'(bus8.bout), 64'(eb));
        chk({tag, "_v"},    64'(bus8.v), 64'(ev));
        $display("op8 %s: %02h - %02h - %0d -> q=%02h bout=%0d v=%0d (exp %02h %0d %0d)",
                 tag, a, b, bin, bus8.q, bus8.bout, bus8.v, eq[7:0], eb, ev);
        last_q8 = eq;
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(bus8.done), 64'(0));
    endtask

    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b, input bit bin);
        longint eq;
        bit     eb, ev, got;
        int     busy_n;
        model(32, longint'(a), longint'(b), bin, eq, eb, ev);
        bus32.a = a; bus32.b = b; bus32.bin = bin; bus32.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus32.start = 1'b0;
        busy_n = 0;
        got = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (bus32.done) begin
                got = 1'b1;
                break;
            end
            if (bus32.busy) busy_n++;
            @(negedge clk);
        end
        chk({tag, "_done"}, 64'(got), 64'(1));
        chk({tag, "_busy"}, 64'(busy_n), 64'(32));
        chk({tag, "_q"},    64'(bus32.q), 64'(eq));
        chk({tag, "_bout"}, 64'(bus32.bout), 64'(eb));
        chk({tag, "_v"},    64'(bus32.v), 64'(ev));
        $display("op32 %s: %08h - %08h - %0d -> q=%08h bout=%0d v=%0d (exp %08h %0d %0d)",
                 tag, a, b, bin, bus32.q, bus32.bout, bus32.v, eq[31:0], eb, ev);
        @(negedge clk);
    endtask

    task automatic b2b8(input int nops);
        longint qq[$];
        bit     qb[$], qv[$];
        longint eq, hold_q;
        bit     eb, ev;
        int     presented, dones;
        logic [7:0] ra, rb;
        bit     rbin;
        hold_q = last_q8;
        ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
        model(8, longint'(ra), longint'(rb), rbin, eq, eb, ev);
        qq.push_back(eq); qb.push_back(eb); qv.push_back(ev);
        bus8.a = ra; bus8.b = rb; bus8.bin = rbin; bus8.start = 1'b1;
        presented = 1;
        dones = 0;
        for (int c = 0; c < nops * 9 + 20 && dones < nops; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus8.done) begin
                eq = qq.pop_front(); eb = qb.pop_front(); ev = qv.pop_front();
                chk("b2b_q",    64'(bus8.q), 64'(eq));
                chk("b2b_bout", 64'(bus8.bout), 64'(eb));
                chk("b2b_v",    64'(bus8.v), 64'(ev));
                $display("b2b op %0d: q=%02h bout=%0d v=%0d (exp %02h %0d %0d)",
                         dones, bus8.q, bus8.bout, bus8.v, eq[7:0], eb, ev);
                hold_q = eq;
                dones++;
                if (presented < nops) begin
                    ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
                    model(8, longint'(ra), longint'(rb), rbin, eq, eb, ev);
                    qq.push_back(eq); qb.push_back(eb); qv.push_back(ev);
                    bus8.a = ra; bus8.b = rb; bus8.bin = rbin;
                    presented++;
                end else begin
                    bus8.start = 1'b0;
                end
            end else begin
                chk("b2b_hold", 64'(bus8.q), 64'(hold_q));
            end
        end
        bus8.start = 1'b0;
        chk("b2b_count", 64'(dones), 64'(nops));
        last_q8 = hold_q;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.bin = 1'b0;
        bus32.start = 1'b0; bus32.a = '0; bus32.b = '0; bus32.bin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus8.busy), 64'(0));
        chk("rst_done", 64'(bus8.done), 64'(0));
        chk("rst_q",    64'(bus8.q), 64'(0));
        chk("rst_bout", 64'(bus8.bout), 64'(0));
        chk("rst_v",    64'(bus8.v), 64'(0));
        chk("rst_q32",  64'(bus32.q), 64'(0));
        rst = 1'b0;
        @(negedge clk);

        run8("t1",   8'h05, 8'h03, 1'b0, -1);
        run8("t2a",  8'h03, 8'h05, 1'b0, -1);
        run8("t2b",  8'h80, 8'h01, 1'b0, -1);
        run8("t3a",  8'h00, 8'h00, 1'b1, -1);
        run8("t3b",  8'h7F, 8'hFF, 1'b0, -1);
        run8("t4",   8'h10, 8'h01, 1'b0, 2);
        for (int i = 0; i < 12; i++) begin
            chk("t4_nodone", 64'(bus8.done), 64'(0));
            @(negedge clk);
        end

        for (int i = 0; i < 20; i++)
            run8("rnd8", 8'($urandom), 8'($urandom), 1'($urandom), -1);

        b2b8(6);

        // Reset in the middle of an operation
        bus8.a = 8'h5A; bus8.b = 8'h21; bus8.bin = 1'b0; bus8.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_busy_pre", 64'(bus8.busy), 64'(1));
        rst = 1'b1;
        #1;
        chk("t6_busy", 64'(bus8.busy), 64'(0));
        chk("t6_done", 64'(bus8.done), 64'(0));
        chk("t6_q",    64'(bus8.q), 64'(0));
        chk("t6_bout", 64'(bus8.bout), 64'(0));
        chk("t6_v",    64'(bus8.v), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        last_q8 = 0;
        @(negedge clk);
        run8("t6_after", 8'h5A, 8'h21, 1'b0, -1);

        run32("t6_32", 32'h0000_0000, 32'h0000_0001, 1'b0);
        run32("t32_v", 32'h8000_0000, 32'h0000_0001, 1'b0);
        for (int i = 0; i < 4; i++)
            run32("rnd32", 32'($urandom), 32'($urandom), 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
